// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and compress-controller state encoding.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int DU      = 10;
  localparam int DV      = 4;

  typedef logic [15:0] coeff_t;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SETTLE, EMIT, DONE} cmp_state_e;

  // d values used by Kyber ciphertext encodings (du/dv across parameter sets)
  function automatic logic d_legal(input logic [15:0] d);
    return d inside {16'd1, 16'd4, 16'd5, 16'd10, 16'd11};
  endfunction
endpackage

// File: rtl/compress_module.sv
// Kyber compress: round(2^d * x / Q) mod 2^d for x < Q, purely combinational.
module compress_module
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  coeff_t      x,
  input  logic [15:0] d,
  output coeff_t      result
);
  logic [31:0] num, quo, mask;

  // Q is odd, so adding (Q-1)/2 before the floor division gives exact rounding
  always_comb begin
    num    = (32'(x) << d) + 32'((Q - 1) / 2);
    quo    = num / 32'(Q);
    mask   = (32'd1 << d) - 32'd1;
    result = coeff_t'(quo & mask);
  end
endmodule

// File: rtl/poly_compress_ctrl.sv
// Walks one polynomial in a 1-cycle RAM, compresses each coefficient, streams results out.
// Build option COMPRESS_PIPE_EN registers the compress result (adds SETTLE, 4 cycles/coeff).
module poly_compress_ctrl
  import kyber_pkg::*;
#(
  parameter int Q  = KYBER_Q,
  parameter int N  = KYBER_N,
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   d_sel,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx
);
  cmp_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   d_q, d_d;
  coeff_t        coeff_q, coeff_d;
  logic          err_q, err_d;
  coeff_t        cmp_res, res_out;

  compress_module #(.Q(Q)) u_compress (
    .x      (coeff_q),
    .d      (d_q),
    .result (cmp_res)
  );

`ifdef COMPRESS_PIPE_EN
  coeff_t res_q, res_d;
  always_comb begin
    res_d = res_q;
    if (state_q == SETTLE) res_d = cmp_res;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end
  assign res_out = res_q;
`else
  assign res_out = cmp_res;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_d     = d_q;
    coeff_d = coeff_q;
    err_d   = 1'b0;
    // abort wins over everything, including a same-cycle handshake
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (d_legal(d_sel)) begin
            d_d     = d_sel;
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          coeff_d = coeff_t'(mem_rdata);
`ifdef COMPRESS_PIPE_EN
          state_d = SETTLE;
`else
          state_d = EMIT;
`endif
        end
        SETTLE: state_d = EMIT;
        EMIT: if (out_ready) begin
          if (idx_q == AW'(N - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_q     <= '0;
      coeff_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      coeff_q <= coeff_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs; state resets to IDLE so every output is 0 under rst
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = err_q;
    mem_rd_en = (state_q == FETCH);
    mem_addr  = mem_rd_en ? idx_q : '0;
    out_valid = (state_q == EMIT);
    out_data  = out_valid ? DW'(res_out) : '0;
    out_idx   = out_valid ? idx_q : '0;
  end
endmodule

// File: tb/tb_poly_compress_ctrl.sv
// Directed scoreboard bench for poly_compress_ctrl (default build timing).
module tb_poly_compress_ctrl;
  import kyber_pkg::*;
  localparam int N = 256;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [15:0] d_sel = '0;
  logic        busy, done, err, mem_rd_en, out_valid;
  logic [7:0]  mem_addr, out_idx;
  logic [15:0] mem_rdata = '0, out_data;

  int checks = 0, errors = 0;

  typedef struct { logic [7:0] idx; logic [15:0] data; } beat_t;
  beat_t       sb[$];
  logic [15:0] mem_arr [N];
  logic [15:0] exp_arr [N];

  poly_compress_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .d_sel(d_sel), .abort(abort),
    .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin mem_arr[i] = '0; exp_arr[i] = '0; end
  endtask

  task automatic set_vec(input int i, input logic [15:0] ram, input logic [15:0] exp);
    mem_arr[i] = ram; exp_arr[i] = exp;
  endtask

  task automatic push_exp(input int cnt);
    beat_t b;
    for (int i = 0; i < cnt; i++) begin
      b.idx = 8'(i); b.data = exp_arr[i]; sb.push_back(b);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);       chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);         chk({nm, "_rd_en"}, mem_rd_en, 0);
    chk({nm, "_addr"}, mem_addr, 0);   chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);   chk({nm, "_idx"}, out_idx, 0);
  endtask

  // Full run: a start ignored mid-run, optional 5-cycle backpressure at bp_idx
  task automatic run_poly(input logic [15:0] d, input int bp_idx, input int exp_done);
    int n, first, bp_cnt;
    logic bp_done;
    logic [15:0] other_d;
    other_d = (d == 16'd11) ? 16'd4 : 16'd11;
    start = 1'b1; d_sel = d; tick(); start = 1'b0;
    n = 1; first = -1; bp_cnt = 0; bp_done = 1'b0;
    while (!done && n < 2000) begin
      if (out_valid && first < 0) first = n;
      start = (n == 2);
      d_sel = (n == 2) ? other_d : d;
      if (bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0) out_ready = 1'b1;
      end else if (!bp_done && out_valid && int'(out_idx) == bp_idx) begin
        out_ready = 1'b0; bp_cnt = 5; bp_done = 1'b1;
      end
      tick(); n++;
    end
    out_ready = 1'b1;
    chk("first_valid_lat", first, 3);
    chk("done_cycle", n, exp_done);
    chk("sb_drained", sb.size(), 0);
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  // Monitor: pops on every real handshake, and holds stalled beats to their value
  initial begin
    logic pend;
    logic [15:0] pd;
    logic [7:0] pi;
    beat_t b;
    pend = 1'b0; pd = '0; pi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (!out_valid || out_data !== pd || out_idx !== pi) begin
            errors++;
            $display("FAIL stall_hold valid=%0b data=%0d idx=%0d expected data=%0d idx=%0d",
                     out_valid, out_data, out_idx, pd, pi);
          end
        end
        if (out_valid && out_ready && !abort) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat idx=%0d data=%0d expected none", out_idx, out_data);
          end else begin
            b = sb.pop_front();
            if (out_idx !== b.idx || out_data !== b.data) begin
              errors++;
              $display("FAIL beat idx=%0d data=%0d expected idx=%0d data=%0d",
                       out_idx, out_data, b.idx, b.data);
            end
          end
        end
        pend = out_valid && !out_ready && !abort;
        pd = out_data; pi = out_idx;
      end
    end
  end

  initial begin
    int k;
    logic saw_done, found;
    clear_vec();
    #2 chk_outputs_zero("por");
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // illegal d rejected with a one-cycle err
    d_sel = 16'd3; start = 1'b1; tick(); start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("err_clear", err, 0);
    chk("err_still_idle", busy, 0);

    // d=11: 3331 mod Q = 2 -> 1, 1664 -> 1024, 3328 -> round(2047.38) = 2047
    clear_vec();
    set_vec(0, 16'd2, 16'd1);     set_vec(1, 16'd0, 16'd0);
    set_vec(2, 16'd1664, 16'd1024); set_vec(3, 16'd3328, 16'd2047);
    push_exp(N);
    run_poly(16'd11, -1, 3 * N + 1);

    // d=4: 3328 -> 16 wraps to 0, 1664 -> 8; 5-cycle stall at idx 6
    clear_vec();
    set_vec(5, 16'd3328, 16'd0); set_vec(6, 16'd1664, 16'd8);
    push_exp(N);
    run_poly(16'd4, 6, 3 * N + 1 + 5);

    // d=10: 832 -> 256, 3328 -> 1024 wraps to 0
    clear_vec();
    set_vec(7, 16'd832, 16'd256); set_vec(8, 16'd3328, 16'd0);
    push_exp(N);
    run_poly(16'd10, -1, 3 * N + 1);

    // d=1: rounding boundary around Q/4
    clear_vec();
    set_vec(0, 16'd1664, 16'd1); set_vec(1, 16'd832, 16'd0); set_vec(2, 16'd833, 16'd1);
    push_exp(N);
    run_poly(16'd1, -1, 3 * N + 1);

    // abort at idx 100 in EMIT with ready high
    clear_vec();
    set_vec(0, 16'd1000, 16'd10);
    push_exp(100);
    d_sel = 16'd5; start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 1000 && !found; k++) begin
      if (out_valid && out_idx == 8'd100) found = 1'b1;
      else tick();
    end
    chk("abort_reach_idx100", found, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_beats", sb.size(), 0);
    push_exp(N);
    run_poly(16'd5, -1, 3 * N + 1);

    // async reset mid-run
    clear_vec();
    set_vec(2, 16'd1664, 16'd1024);
    push_exp(N);
    d_sel = 16'd11; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #3 rst = 1'b1;
    #1 chk_outputs_zero("mid_rst");
    sb.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
